mem_bus_arb: RTL and testbench

Arbiter and sequencer for the single shared memory bus used by instruction fetch (IF) and the memory-access stage (MEM). It accepts one outstanding request from each requester, grants the bus round-robin, and drives the bus with registered outputs. It returns data plus a one-cycle ack (or error on timeout), and raises stall requests to the pipeline controller while a requester waits. It sits between the IF/MEM stages and the external instruction/data memory bus.

---
 rtl/mem_bus_arb_pkg.sv | 33 +++
 rtl/mem_bus_arb_if.sv | 51 +++++
 rtl/mem_bus_arb_wdt.sv | 37 +++
 rtl/mem_bus_arb.sv | 159 +++++++++++++++
 tb/tb_mem_bus_arb.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arb_pkg.sv
// Shared types and constants for the IF/MEM memory bus arbiter.
package mem_bus_arb_pkg;

    localparam int unsigned AW_DEF      = 32;
    localparam int unsigned DW_DEF      = 32;
    localparam int unsigned TIMEOUT_DEF = 255;
    localparam logic        RST_ACTIVE  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } gnt_e;

    // Round-robin pick: on a tie the requester not served last wins.
    function automatic gnt_e pick_grant(input logic if_req, input logic mem_req,
                                        input gnt_e last);
        gnt_e win;
        win = GNT_IF;
        if (if_req && mem_req) begin
            win = (last == GNT_IF) ? GNT_MEM : GNT_IF;
        end else if (mem_req) begin
            win = GNT_MEM;
        end
        return win;
    endfunction

endpackage

// File: rtl/mem_bus_arb_if.sv
// Requester and memory-bus signal bundle; master is the arbiter's view.
interface mem_bus_arb_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_ack;
    logic            if_err;
    logic [DW-1:0]   if_rdata;

    logic            mem_req;
    logic            mem_we;
    logic [DW/8-1:0] mem_sel;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_ack;
    logic            mem_err;
    logic [DW-1:0]   mem_rdata;

    logic            bus_req;
    logic            bus_we;
    logic [DW/8-1:0] bus_sel;
    logic [AW-1:0]   bus_addr;
    logic [DW-1:0]   bus_wdata;
    logic            bus_ack;
    logic [DW-1:0]   bus_rdata;

    logic            stallreq_if;
    logic            stallreq_mem;

    modport master (
        input  if_req, if_addr,
        input  mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
        input  bus_ack, bus_rdata,
        output if_ack, if_err, if_rdata,
        output mem_ack, mem_err, mem_rdata,
        output bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
        output stallreq_if, stallreq_mem
    );

    modport slave (
        output if_req, if_addr,
        output mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
        output bus_ack, bus_rdata,
        input  if_ack, if_err, if_rdata,
        input  mem_ack, mem_err, mem_rdata,
        input  bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
        input  stallreq_if, stallreq_mem
    );
endinterface

// File: rtl/mem_bus_arb_wdt.sv
// Bus transaction watchdog: counts waited cycles, flags expiry at TIMEOUT.
module mem_bus_wdt
    import mem_bus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    localparam int unsigned CW     = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam logic [CW-1:0] TC = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturates at the terminal count so a late enable cannot wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != TC)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == TC);
endmodule

// File: rtl/mem_bus_arb.sv
// Round-robin arbiter/sequencer for the shared IF/MEM memory bus.
//   state   | meaning
//   IDLE    | sample requests, grant and latch the winner's fields
//   BUS     | bus_req held, wait for bus_ack or watchdog expiry
//   RESP    | one-cycle ack/err pulse to the granted requester
module mem_bus_arb
    import mem_bus_arb_pkg::*;
#(
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_bus_arb_if.master bus_if
);
    state_e          state_q, state_d;
    gnt_e            gnt_q, gnt_d;
    gnt_e            last_q, last_d;
    logic            bus_req_q, bus_req_d;
    logic            bus_we_q, bus_we_d;
    logic [DW/8-1:0] bus_sel_q, bus_sel_d;
    logic [AW-1:0]   bus_addr_q, bus_addr_d;
    logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
    logic            if_ack_q, if_ack_d;
    logic            if_err_q, if_err_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic            mem_ack_q, mem_ack_d;
    logic            mem_err_q, mem_err_d;
    logic [DW-1:0]   mem_rdata_q, mem_rdata_d;

    logic            wdt_expire;
    gnt_e            win;
    logic [DW-1:0]   rd;

    mem_bus_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q == ST_IDLE),
        .en     ((state_q == ST_BUS) && !bus_if.bus_ack),
        .expire (wdt_expire)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_ack_d    = 1'b0;
        if_err_d    = 1'b0;
        mem_ack_d   = 1'b0;
        mem_err_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        win         = pick_grant(bus_if.if_req, bus_if.mem_req, last_q);
        rd          = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus_if.if_req || bus_if.mem_req) begin
                    gnt_d     = win;
                    last_d    = win;
                    bus_req_d = 1'b1;
                    state_d   = ST_BUS;
                    if (win == GNT_MEM) begin
                        bus_we_d    = bus_if.mem_we;
                        bus_sel_d   = bus_if.mem_sel;
                        bus_addr_d  = bus_if.mem_addr;
                        bus_wdata_d = bus_if.mem_wdata;
                    end else begin
                        bus_we_d    = 1'b0;
                        bus_sel_d   = '1;
                        bus_addr_d  = bus_if.if_addr;
                        bus_wdata_d = '0;
                    end
                end
            end
            // bus_ack is checked first so it wins over a same-cycle expiry.
            ST_BUS: begin
                if (bus_if.bus_ack || wdt_expire) begin
                    bus_req_d = 1'b0;
                    state_d   = ST_RESP;
                    if (bus_if.bus_ack && !bus_we_q) begin
                        rd = bus_if.bus_rdata;
                    end
                    if (gnt_q == GNT_MEM) begin
                        mem_rdata_d = rd;
                        mem_ack_d   = bus_if.bus_ack;
                        mem_err_d   = !bus_if.bus_ack;
                    end else begin
                        if_rdata_d  = rd;
                        if_ack_d    = bus_if.bus_ack;
                        if_err_d    = !bus_if.bus_ack;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            state_q     <= ST_IDLE;
            gnt_q       <= GNT_IF;
            last_q      <= GNT_IF;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            mem_ack_q   <= 1'b0;
            mem_err_q   <= 1'b0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_ack_q    <= if_ack_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            mem_ack_q   <= mem_ack_d;
            mem_err_q   <= mem_err_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign bus_if.bus_req      = bus_req_q;
    assign bus_if.bus_we       = bus_we_q;
    assign bus_if.bus_sel      = bus_sel_q;
    assign bus_if.bus_addr     = bus_addr_q;
    assign bus_if.bus_wdata    = bus_wdata_q;
    assign bus_if.if_ack       = if_ack_q;
    assign bus_if.if_err       = if_err_q;
    assign bus_if.if_rdata     = if_rdata_q;
    assign bus_if.mem_ack      = mem_ack_q;
    assign bus_if.mem_err      = mem_err_q;
    assign bus_if.mem_rdata    = mem_rdata_q;
    // Combinational so the pipeline freezes in the cycle the request appears.
    assign bus_if.stallreq_if  = bus_if.if_req & ~if_ack_q;
    assign bus_if.stallreq_mem = bus_if.mem_req & ~mem_ack_q;
endmodule

// File: tb/tb_mem_bus_arb.sv
// Directed bench for mem_bus_arb with TIMEOUT = 4; cycle 0 is the request-sampling cycle.
module tb_mem_bus_arb;
    import mem_bus_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_bus_arb_if #(.AW(32), .DW(32)) bif ();

    mem_bus_arb #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bif)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bif.if_req    = 1'b0;
        bif.if_addr   = '0;
        bif.mem_req   = 1'b0;
        bif.mem_we    = 1'b0;
        bif.mem_sel   = '0;
        bif.mem_addr  = '0;
        bif.mem_wdata = '0;
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = '0;
    endtask

    // Leaves the bench one cycle past reset with rst released: that cycle is a fresh cycle 0.
    task automatic reset_dut();
        rst = 1'b0;
        idle_in();
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        reset_dut();
        #1;
        chk("rst_bus_req",   bif.bus_req, 1'b0);
        chk("rst_bus_addr",  bif.bus_addr, 32'h0);
        chk("rst_bus_sel",   bif.bus_sel, 4'h0);
        chk("rst_if_ack",    bif.if_ack, 1'b0);
        chk("rst_mem_ack",   bif.mem_ack, 1'b0);
        chk("rst_mem_rdata", bif.mem_rdata, 32'h0);

        // Lone MEM load, zero-wait memory
        bif.mem_req = 1'b1; bif.mem_we = 1'b0; bif.mem_sel = 4'hF; bif.mem_addr = 32'h0000_0100;
        #1;
        chk("ld_stall_c0", bif.stallreq_mem, 1'b1);
        chk("ld_breq_c0",  bif.bus_req, 1'b0);
        cyc();
        bif.bus_ack = 1'b1; bif.bus_rdata = 32'hDEAD_BEEF;
        #1;
        chk("ld_breq_c1",  bif.bus_req, 1'b1);
        chk("ld_addr_c1",  bif.bus_addr, 32'h0000_0100);
        chk("ld_stall_c1", bif.stallreq_mem, 1'b1);
        cyc();
        bif.bus_ack = 1'b0;
        #1;
        chk("ld_ack_c2",   bif.mem_ack, 1'b1);
        chk("ld_rdata_c2", bif.mem_rdata, 32'hDEAD_BEEF);
        chk("ld_breq_c2",  bif.bus_req, 1'b0);
        chk("ld_stall_c2", bif.stallreq_mem, 1'b0);
        bif.mem_req = 1'b0;
        cyc();
        #1;
        chk("ld_ack_c3",   bif.mem_ack, 1'b0);

        // Tie from reset: MEM (store) first, IF on the next tie, then MEM again
        reset_dut();
        bif.if_req = 1'b1; bif.if_addr = 32'h0000_1000;
        bif.mem_req = 1'b1; bif.mem_we = 1'b1; bif.mem_sel = 4'b0001;
        bif.mem_addr = 32'h0000_0300; bif.mem_wdata = 32'h0000_00AA;
        #1;
        chk("arb_stall_if_c0", bif.stallreq_if, 1'b1);
        cyc();
        bif.bus_ack = 1'b1; bif.bus_rdata = 32'hAAAA_0001;
        #1;
        chk("arb_addr_mem1", bif.bus_addr, 32'h0000_0300);
        chk("arb_we_mem1",   bif.bus_we, 1'b1);
        cyc();
        bif.bus_ack = 1'b0;
        #1;
        chk("arb_mem_ack1",  bif.mem_ack, 1'b1);
        chk("arb_if_ack1",   bif.if_ack, 1'b0);
        chk("arb_st_rdata",  bif.mem_rdata, 32'h0);
        chk("arb_stall_if",  bif.stallreq_if, 1'b1);
        bif.mem_addr = 32'h0000_0304;
        cyc();
        cyc();
        bif.bus_ack = 1'b1; bif.bus_rdata = 32'hBBBB_0002;
        #1;
        chk("arb_addr_if",   bif.bus_addr, 32'h0000_1000);
        chk("arb_we_if",     bif.bus_we, 1'b0);
        chk("arb_sel_if",    bif.bus_sel, 4'hF);
        cyc();
        bif.bus_ack = 1'b0;
        #1;
        chk("arb_if_ack",    bif.if_ack, 1'b1);
        chk("arb_if_rdata",  bif.if_rdata, 32'hBBBB_0002);
        chk("arb_mem_ack_n", bif.mem_ack, 1'b0);
        bif.if_addr = 32'h0000_1004;
        cyc();
        cyc();
        bif.bus_ack = 1'b1; bif.bus_rdata = 32'hCCCC_0003;
        #1;
        chk("arb_addr_mem2", bif.bus_addr, 32'h0000_0304);
        cyc();
        bif.bus_ack = 1'b0;
        #1;
        chk("arb_mem_ack2",  bif.mem_ack, 1'b1);
        bif.if_req = 1'b0; bif.mem_req = 1'b0;
        cyc();

        // MEM store with 3 wait cycles; request fields change mid-flight
        bif.mem_req = 1'b1; bif.mem_we = 1'b1; bif.mem_sel = 4'b0011;
        bif.mem_addr = 32'h0000_0200; bif.mem_wdata = 32'h1234_5678;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            if (i == 2) begin
                bif.mem_addr = 32'h0000_FFFF; bif.mem_wdata = 32'h0; bif.mem_sel = 4'hC;
            end
            #1;
            chk($sformatf("st_breq_c%0d", i),  bif.bus_req, 1'b1);
            chk($sformatf("st_addr_c%0d", i),  bif.bus_addr, 32'h0000_0200);
            chk($sformatf("st_wdata_c%0d", i), bif.bus_wdata, 32'h1234_5678);
            chk($sformatf("st_sel_c%0d", i),   bif.bus_sel, 4'b0011);
            chk($sformatf("st_ack_c%0d", i),   bif.mem_ack, 1'b0);
        end
        cyc();
        bif.bus_ack = 1'b1; bif.bus_rdata = 32'h5555_5555;
        #1;
        chk("st_breq_c4", bif.bus_req, 1'b1);
        chk("st_we_c4",   bif.bus_we, 1'b1);
        cyc();
        bif.bus_ack = 1'b0;
        #1;
        chk("st_ack_c5",   bif.mem_ack, 1'b1);
        chk("st_rdata_c5", bif.mem_rdata, 32'h0);
        chk("st_breq_c5",  bif.bus_req, 1'b0);
        bif.mem_req = 1'b0;
        cyc();

        // IF with no bus_ack: timeout after TIMEOUT = 4
        bif.if_req = 1'b1; bif.if_addr = 32'h0000_2000;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            #1;
            chk($sformatf("to_breq_c%0d", i), bif.bus_req, 1'b1);
            chk($sformatf("to_err_c%0d", i),  bif.if_err, 1'b0);
        end
        cyc();
        #1;
        chk("to_err_c6",   bif.if_err, 1'b1);
        chk("to_ack_c6",   bif.if_ack, 1'b0);
        chk("to_rdata_c6", bif.if_rdata, 32'h0);
        chk("to_breq_c6",  bif.bus_req, 1'b0);
        bif.if_req = 1'b0;
        cyc();
        #1;
        chk("to_err_c7",   bif.if_err, 1'b0);

        // bus_ack in the expiry cycle: ack wins
        bif.if_req = 1'b1; bif.if_addr = 32'h0000_2004;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            if (i == 5) begin
                bif.bus_ack = 1'b1; bif.bus_rdata = 32'h7777_0005;
            end
            #1;
            chk($sformatf("tx_breq_c%0d", i), bif.bus_req, 1'b1);
        end
        cyc();
        bif.bus_ack = 1'b0;
        #1;
        chk("tx_ack_c6",   bif.if_ack, 1'b1);
        chk("tx_err_c6",   bif.if_err, 1'b0);
        chk("tx_rdata_c6", bif.if_rdata, 32'h7777_0005);
        bif.if_req = 1'b0;
        cyc();

        // Reset during BUS, then a late bus_ack
        bif.if_req = 1'b1; bif.if_addr = 32'h0000_3000;
        cyc();
        #1;
        chk("mr_breq_c1", bif.bus_req, 1'b1);
        rst = 1'b0; bif.if_req = 1'b0;
        cyc();
        rst = 1'b1; bif.bus_ack = 1'b1; bif.bus_rdata = 32'h0000_0099;
        #1;
        chk("mr_breq_c2", bif.bus_req, 1'b0);
        chk("mr_addr_c2", bif.bus_addr, 32'h0);
        cyc();
        bif.bus_ack = 1'b0;
        #1;
        chk("mr_ack_c3",   bif.if_ack, 1'b0);
        chk("mr_err_c3",   bif.if_err, 1'b0);
        chk("mr_rdata_c3", bif.if_rdata, 32'h0);
        chk("mr_breq_c3",  bif.bus_req, 1'b0);

        bif.mem_req = 1'b1; bif.mem_we = 1'b0; bif.mem_sel = 4'hF; bif.mem_addr = 32'h0000_0400;
        cyc();
        bif.bus_ack = 1'b1; bif.bus_rdata = 32'h0BAD_F00D;
        #1;
        chk("mr_next_breq", bif.bus_req, 1'b1);
        chk("mr_next_addr", bif.bus_addr, 32'h0000_0400);
        cyc();
        bif.bus_ack = 1'b0;
        #1;
        chk("mr_next_ack",   bif.mem_ack, 1'b1);
        chk("mr_next_rdata", bif.mem_rdata, 32'h0BAD_F00D);
        bif.mem_req = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
